// File: rtl/leaf_stream_pkg.sv
// rtl/leaf_stream_pkg.sv - shared field layout, state type and packet packing for the leaf stream sender
package leaf_stream_pkg;

    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

    // Field offsets, MSB->LSB: valid | leaf | port | addr | payload
    localparam int PAYLOAD_LSB = 0;
    localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
    localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT   = LEAF_LSB + NUM_LEAF_BITS;

    localparam logic [NUM_PORT_BITS-1:0] CREDIT_PORT_DEFAULT = '0;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    function automatic logic [PACKET_BITS-1:0] pack_packet(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        return {1'b1, leaf, port, addr, payload};
    endfunction

endpackage

// File: rtl/leaf_stream_tx_fifo.sv
// rtl/leaf_stream_tx_fifo.sv - small synchronous staging FIFO with combinational head
module leaf_stream_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_COUNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/leaf_stream_tx.sv
// rtl/leaf_stream_tx.sv - credit-based sender leaf packing a user stream into BFT packets; optional LEAF_STREAM_TX_STATS_EN counters
module leaf_stream_tx
    import leaf_stream_pkg::*;
#(
    parameter int PACKET_BITS        = 49,
    parameter int PAYLOAD_BITS       = 32,
    parameter int NUM_LEAF_BITS      = 5,
    parameter int NUM_PORT_BITS      = 4,
    parameter int NUM_ADDR_BITS      = 7,
    parameter int NUM_BRAM_ADDR_BITS = 7,
    parameter logic [NUM_PORT_BITS-1:0] CREDIT_PORT = CREDIT_PORT_DEFAULT,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_LEAF_BITS-1:0]      dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]      dest_port,
    input  logic [PAYLOAD_BITS-1:0]       din_leaf_user2interface,
    input  logic                          vld_user2interface,
    output logic                          ack_interface2user,
    input  logic [PACKET_BITS-1:0]        din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]        dout_leaf_interface2bft,
    input  logic                          resend,
    output logic [NUM_BRAM_ADDR_BITS:0]   credit_avail,
    output logic                          credit_err
`ifdef LEAF_STREAM_TX_STATS_EN
    ,
    output logic [31:0]                   pkt_cnt,
    output logic [31:0]                   stall_cnt
`endif
);

    localparam int CREDIT_W = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [CREDIT_W:0] CREDIT_MAX = (CREDIT_W+1)'(2**NUM_BRAM_ADDR_BITS);

    tx_state_t                    state_q, state_d;
    logic [PACKET_BITS-1:0]       dout_q, dout_d;
    logic [NUM_ADDR_BITS-1:0]     wr_addr_q, wr_addr_d;
    logic [CREDIT_W-1:0]          credit_q, credit_d;
    logic                         err_q, err_d;

    logic                         fifo_full;
    logic                         fifo_empty;
    logic [PAYLOAD_BITS-1:0]      fifo_head;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         can_send;

    logic                         ret_valid;
    logic [CREDIT_W-1:0]          ret_amount;
    logic [CREDIT_W:0]            credit_sum;
    logic                         unused_din_bits;

    // Accept is driven from registered FIFO state only, so a full FIFO
    // refuses data even in a cycle where it also pops.
    assign ack_interface2user = !fifo_full;
    assign fifo_push          = vld_user2interface && ack_interface2user;
    assign can_send           = !fifo_empty && (credit_q != '0);

    // A credit return is any valid packet addressed to the credit port;
    // the returned count lives in the low payload bits.
    assign ret_valid  = din_leaf_bft2interface[VALID_BIT]
                        && (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == CREDIT_PORT);
    assign ret_amount = ret_valid ? din_leaf_bft2interface[CREDIT_W-1:0] : '0;

    assign unused_din_bits = ^{din_leaf_bft2interface[VALID_BIT-1:LEAF_LSB],
                               din_leaf_bft2interface[PORT_LSB-1:CREDIT_W]};

    assign dout_leaf_interface2bft = resend ? '0 : dout_q;
    assign credit_avail            = credit_q;
    assign credit_err              = err_q;

    leaf_stream_tx_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (din_leaf_user2interface),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Output FSM: resend freezes the held packet; otherwise load the next
    // packet when data and credit exist, else go idle with a zero word.
    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        wr_addr_d = wr_addr_q;
        fifo_pop  = 1'b0;
        if (!resend) begin
            if (can_send) begin
                dout_d    = pack_packet(dest_leaf, dest_port, wr_addr_q, fifo_head);
                wr_addr_d = wr_addr_q + 1'b1;
                fifo_pop  = 1'b1;
                state_d   = TX_SEND;
            end else begin
                dout_d  = '0;
                state_d = TX_IDLE;
            end
        end
    end

    // Credit update: a dispatch and a return may land on the same edge;
    // overflow past the remote buffer depth clamps and flags an error.
    always_comb begin
        credit_sum = {1'b0, credit_q} + {1'b0, ret_amount} - {{CREDIT_W{1'b0}}, fifo_pop};
        credit_d   = credit_sum[CREDIT_W-1:0];
        err_d      = err_q;
        if (credit_sum > CREDIT_MAX) begin
            credit_d = CREDIT_MAX[CREDIT_W-1:0];
            err_d    = 1'b1;
        end
    end

    // State, output register, sequence address and credit registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            dout_q    <= '0;
            wr_addr_q <= '0;
            credit_q  <= CREDIT_MAX[CREDIT_W-1:0];
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            wr_addr_q <= wr_addr_d;
            credit_q  <= credit_d;
            err_q     <= err_d;
        end
    end

`ifdef LEAF_STREAM_TX_STATS_EN
    // Issue and credit-starvation counters, free-running with wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (fifo_pop) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if ((fifo_count != '0) && (credit_q == '0)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_fifo_count;
    assign unused_fifo_count = ^fifo_count;
`endif

endmodule
